// File: rtl/mem_wb_pipe_pkg.sv
// Shared types and constants for the MEM/WB pipeline register.
// The *_NOP / *_DISABLE constants stand in for the openmips define.v macros.
package mem_wb_pipe_pkg;

  // Reset asserted level (active-low).
  localparam logic RSTN_ENABLE   = 1'b0;
  // Write-enable value for a squashed or idle channel.
  localparam logic WRITE_DISABLE = 1'b0;

  // Buffer state. The encoding equals the number of held entries, so the
  // state register doubles as the occupancy output.
  typedef enum logic [1:0] {
    SKID_EMPTY = 2'd0,
    SKID_ONE   = 2'd1,
    SKID_FULL  = 2'd2
  } skid_state_e;

  // Width of one packed entry: {wd, wreg, wdata} per channel plus {whilo, hi, lo}.
  function automatic int payload_width(input int ports, input int addr_w, input int data_w);
    return ports * (addr_w + 1 + data_w) + 1 + 2 * data_w;
  endfunction

endpackage

// File: rtl/pipe_skid.sv
// Generic one- or two-entry pipeline buffer with strict FIFO order.
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both 1. The producer holds valid and data stable until ready; ready never
// depends on valid on the same side. out_valid and out_data come straight
// from registers.
//
// DEPTH=1: plain register; in_ready = empty | out_ready (combinational).
// DEPTH=2: head + skid register; in_ready comes from a flop and has no
//          combinational path from out_ready.
// The FSM state is visible on the occupancy output.
module pipe_skid
  import mem_wb_pipe_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       occupancy
);

  skid_state_e      state_q;
  skid_state_e      state_d;
  logic [WIDTH-1:0] head_q;
  logic [WIDTH-1:0] skid_q;
  logic             load_head_in;
  logic             load_head_skid;
  logic             load_skid;
  logic             accept;
  logic             drain;

  assign out_valid = (state_q != SKID_EMPTY);
  assign out_data  = head_q;
  assign occupancy = state_q;
  assign accept    = in_valid & in_ready;
  assign drain     = out_valid & out_ready;

  // Next state and register load selects. Flush wins over accept and drain.
  always_comb begin
    state_d        = state_q;
    load_head_in   = 1'b0;
    load_head_skid = 1'b0;
    load_skid      = 1'b0;
    if (flush) begin
      state_d = SKID_EMPTY;
    end else begin
      case (state_q)
        SKID_EMPTY: begin
          if (accept) begin
            load_head_in = 1'b1;
            state_d      = SKID_ONE;
          end
        end
        SKID_ONE: begin
          if (accept && drain) begin
            load_head_in = 1'b1;
          end else if (accept) begin
            load_skid = 1'b1;
            state_d   = SKID_FULL;
          end else if (drain) begin
            state_d = SKID_EMPTY;
          end
        end
        SKID_FULL: begin
          // in_ready is 0 here, so only a drain can happen.
          if (drain) begin
            load_head_skid = 1'b1;
            state_d        = SKID_ONE;
          end
        end
        default: state_d = SKID_EMPTY;
      endcase
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (rst == RSTN_ENABLE) begin
      state_q <= SKID_EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  // Payload registers; cleared on reset so no stale data survives it.
  always_ff @(posedge clk or negedge rst) begin
    if (rst == RSTN_ENABLE) begin
      head_q <= '0;
      skid_q <= '0;
    end else begin
      if (load_head_in) begin
        head_q <= in_data;
      end else if (load_head_skid) begin
        head_q <= skid_q;
      end
      if (load_skid) begin
        skid_q <= in_data;
      end
    end
  end

  generate
    if (DEPTH == 1) begin : g_comb_ready
      // Single register: room exists when empty or when the head leaves now.
      assign in_ready = (rst != RSTN_ENABLE) & ((state_q == SKID_EMPTY) | out_ready);
    end else begin : g_reg_ready
      logic ready_q;
      // Registered ready: high whenever the next state still has a free slot.
      // Resets to 1 so the block is ready on the first cycle after reset.
      always_ff @(posedge clk or negedge rst) begin
        if (rst == RSTN_ENABLE) begin
          ready_q <= 1'b1;
        end else begin
          ready_q <= (state_d != SKID_FULL);
        end
      end
      assign in_ready = (rst != RSTN_ENABLE) & ready_q;
    end
  endgenerate

endmodule

// File: rtl/mem_wb_pipe.sv
// MEM/WB pipeline register with PORTS writeback channels and an optional
// HI/LO write. Packs the mem-stage entry, squashes writes to register 0,
// buffers through pipe_skid and zeroes every wb_* output while empty.
module mem_wb_pipe
  import mem_wb_pipe_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int PORTS  = 1,
  parameter int DEPTH  = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     mem_valid,
  output logic                     mem_ready,
  input  logic [PORTS*ADDR_W-1:0]  mem_wd,
  input  logic [PORTS-1:0]         mem_wreg,
  input  logic [PORTS*DATA_W-1:0]  mem_wdata,
  input  logic                     mem_whilo,
  input  logic [DATA_W-1:0]        mem_hi,
  input  logic [DATA_W-1:0]        mem_lo,
  output logic                     wb_valid,
  input  logic                     wb_ready,
  output logic [PORTS*ADDR_W-1:0]  wb_wd,
  output logic [PORTS-1:0]         wb_wreg,
  output logic [PORTS*DATA_W-1:0]  wb_wdata,
  output logic                     wb_whilo,
  output logic [DATA_W-1:0]        wb_hi,
  output logic [DATA_W-1:0]        wb_lo,
  output logic [1:0]               occupancy
);

  localparam int CH_W      = ADDR_W + 1 + DATA_W;
  localparam int HILO_W    = 1 + 2 * DATA_W;
  localparam int HILO_LSB  = PORTS * CH_W;
  localparam int PAYLOAD_W = payload_width(PORTS, ADDR_W, DATA_W);

  logic [PAYLOAD_W-1:0] in_payload;
  logic [PAYLOAD_W-1:0] out_payload;
  logic                 head_valid;

  // Pack the incoming entry; a write to register 0 is stored as disabled.
  always_comb begin
    in_payload = '0;
    for (int k = 0; k < PORTS; k++) begin
      in_payload[k*CH_W +: CH_W] = {mem_wd[k*ADDR_W +: ADDR_W],
                                    mem_wreg[k] & (mem_wd[k*ADDR_W +: ADDR_W] != '0),
                                    mem_wdata[k*DATA_W +: DATA_W]};
    end
    in_payload[HILO_LSB +: HILO_W] = {mem_whilo, mem_hi, mem_lo};
  end

  pipe_skid #(
    .WIDTH(PAYLOAD_W),
    .DEPTH(DEPTH)
  ) u_skid (
    .clk      (clk),
    .rst      (rst),
    .flush    (flush),
    .in_valid (mem_valid),
    .in_ready (mem_ready),
    .in_data  (in_payload),
    .out_valid(head_valid),
    .out_ready(wb_ready),
    .out_data (out_payload),
    .occupancy(occupancy)
  );

  assign wb_valid = head_valid;

  // Unpack the head; drive NOP address, write-disable and zero word when empty.
  always_comb begin
    wb_wd    = '0;
    wb_wreg  = {PORTS{WRITE_DISABLE}};
    wb_wdata = '0;
    wb_whilo = WRITE_DISABLE;
    wb_hi    = '0;
    wb_lo    = '0;
    if (head_valid) begin
      for (int k = 0; k < PORTS; k++) begin
        {wb_wd[k*ADDR_W +: ADDR_W], wb_wreg[k], wb_wdata[k*DATA_W +: DATA_W]} =
          out_payload[k*CH_W +: CH_W];
      end
      {wb_whilo, wb_hi, wb_lo} = out_payload[HILO_LSB +: HILO_W];
    end
  end

endmodule

// File: tb/tb_mem_wb_pipe.sv
// Directed bench for mem_wb_pipe: a DEPTH=2/PORTS=2 instance and a
// DEPTH=1/PORTS=1 instance share clock and reset.
module tb_mem_wb_pipe;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;
  localparam int SB2_W  = 2 * (ADDR_W + 1 + DATA_W) + 1 + 2 * DATA_W;
  localparam int SB1_W  = 1 * (ADDR_W + 1 + DATA_W) + 1 + 2 * DATA_W;

  // ---------------- clock / reset ----------------
  logic clk;
  logic rst;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- DEPTH=2, PORTS=2 instance ----------------
  logic        d2_flush, d2_mem_valid, d2_mem_ready, d2_mem_whilo;
  logic [9:0]  d2_mem_wd;
  logic [1:0]  d2_mem_wreg;
  logic [63:0] d2_mem_wdata;
  logic [31:0] d2_mem_hi, d2_mem_lo;
  logic        d2_wb_valid, d2_wb_ready, d2_wb_whilo;
  logic [9:0]  d2_wb_wd;
  logic [1:0]  d2_wb_wreg;
  logic [63:0] d2_wb_wdata;
  logic [31:0] d2_wb_hi, d2_wb_lo;
  logic [1:0]  d2_occupancy;

  mem_wb_pipe #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .PORTS(2), .DEPTH(2)) u_dut2 (
    .clk(clk), .rst(rst), .flush(d2_flush),
    .mem_valid(d2_mem_valid), .mem_ready(d2_mem_ready),
    .mem_wd(d2_mem_wd), .mem_wreg(d2_mem_wreg), .mem_wdata(d2_mem_wdata),
    .mem_whilo(d2_mem_whilo), .mem_hi(d2_mem_hi), .mem_lo(d2_mem_lo),
    .wb_valid(d2_wb_valid), .wb_ready(d2_wb_ready),
    .wb_wd(d2_wb_wd), .wb_wreg(d2_wb_wreg), .wb_wdata(d2_wb_wdata),
    .wb_whilo(d2_wb_whilo), .wb_hi(d2_wb_hi), .wb_lo(d2_wb_lo),
    .occupancy(d2_occupancy)
  );

  // ---------------- DEPTH=1, PORTS=1 instance ----------------
  logic        d1_flush, d1_mem_valid, d1_mem_ready, d1_mem_whilo;
  logic [4:0]  d1_mem_wd;
  logic [0:0]  d1_mem_wreg;
  logic [31:0] d1_mem_wdata, d1_mem_hi, d1_mem_lo;
  logic        d1_wb_valid, d1_wb_ready, d1_wb_whilo;
  logic [4:0]  d1_wb_wd;
  logic [0:0]  d1_wb_wreg;
  logic [31:0] d1_wb_wdata, d1_wb_hi, d1_wb_lo;
  logic [1:0]  d1_occupancy;

  mem_wb_pipe #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .PORTS(1), .DEPTH(1)) u_dut1 (
    .clk(clk), .rst(rst), .flush(d1_flush),
    .mem_valid(d1_mem_valid), .mem_ready(d1_mem_ready),
    .mem_wd(d1_mem_wd), .mem_wreg(d1_mem_wreg), .mem_wdata(d1_mem_wdata),
    .mem_whilo(d1_mem_whilo), .mem_hi(d1_mem_hi), .mem_lo(d1_mem_lo),
    .wb_valid(d1_wb_valid), .wb_ready(d1_wb_ready),
    .wb_wd(d1_wb_wd), .wb_wreg(d1_wb_wreg), .wb_wdata(d1_wb_wdata),
    .wb_whilo(d1_wb_whilo), .wb_hi(d1_wb_hi), .wb_lo(d1_wb_lo),
    .occupancy(d1_occupancy)
  );

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_fail   = 0;
  int drained1 = 0;

  task automatic check(input string tag, input logic [159:0] obs, input logic [159:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // ---------------- scoreboards ----------------
  logic [SB2_W-1:0] exp2_q[$];
  logic [SB1_W-1:0] exp1_q[$];

  // DEPTH=2 scoreboard: compare head on every drain, queue the squashed entry on accept.
  always @(negedge clk) begin
    if (rst) begin
      if (d2_wb_valid && d2_wb_ready) begin
        check("sb2_qnonempty", 160'(exp2_q.size() != 0), 160'(1));
        if (exp2_q.size() != 0)
          check("sb2_head",
                160'({d2_wb_wd, d2_wb_wreg, d2_wb_wdata, d2_wb_whilo, d2_wb_hi, d2_wb_lo}),
                160'(exp2_q.pop_front()));
      end
      if (d2_flush) begin
        exp2_q.delete();
      end else if (d2_mem_valid && d2_mem_ready) begin
        exp2_q.push_back({d2_mem_wd,
                          d2_mem_wreg[1] & (d2_mem_wd[9:5] != 5'd0),
                          d2_mem_wreg[0] & (d2_mem_wd[4:0] != 5'd0),
                          d2_mem_wdata, d2_mem_whilo, d2_mem_hi, d2_mem_lo});
      end
    end
  end

  // DEPTH=1 scoreboard.
  always @(negedge clk) begin
    if (rst) begin
      if (d1_wb_valid && d1_wb_ready) begin
        drained1++;
        check("sb1_qnonempty", 160'(exp1_q.size() != 0), 160'(1));
        if (exp1_q.size() != 0)
          check("sb1_head",
                160'({d1_wb_wd, d1_wb_wreg, d1_wb_wdata, d1_wb_whilo, d1_wb_hi, d1_wb_lo}),
                160'(exp1_q.pop_front()));
      end
      if (d1_flush) begin
        exp1_q.delete();
      end else if (d1_mem_valid && d1_mem_ready) begin
        exp1_q.push_back({d1_mem_wd, d1_mem_wreg[0] & (d1_mem_wd != 5'd0),
                          d1_mem_wdata, d1_mem_whilo, d1_mem_hi, d1_mem_lo});
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic neg();
    @(negedge clk);
  endtask

  task automatic drive2(input logic v, input logic [9:0] wd, input logic [1:0] wreg,
                        input logic [63:0] wdata, input logic whilo,
                        input logic [31:0] hi, input logic [31:0] lo);
    d2_mem_valid = v;
    d2_mem_wd    = wd;
    d2_mem_wreg  = wreg;
    d2_mem_wdata = wdata;
    d2_mem_whilo = whilo;
    d2_mem_hi    = hi;
    d2_mem_lo    = lo;
  endtask

  task automatic idle2();
    drive2(1'b0, '0, '0, '0, 1'b0, '0, '0);
  endtask

  task automatic drive1(input logic v, input logic [4:0] wd, input logic [31:0] wdata);
    d1_mem_valid = v;
    d1_mem_wd    = wd;
    d1_mem_wreg  = 1'b1;
    d1_mem_wdata = wdata;
    d1_mem_whilo = v;
    d1_mem_hi    = wdata + 32'd1;
    d1_mem_lo    = wdata + 32'd2;
  endtask

  // Simple data word for the back-pressure / flush tests.
  task automatic drive_tag(input logic [31:0] tag);
    drive2(1'b1, {5'd2, 5'd1}, 2'b11, {tag, tag}, 1'b0, tag, tag);
  endtask

  // Watchdog: the run is bounded by fixed cycle counts, this is a backstop.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    int acc_count;
    logic acc;

    rst = 1'b1;
    d2_flush = 1'b0; d2_wb_ready = 1'b0; idle2();
    d1_flush = 1'b0; d1_wb_ready = 1'b0; drive1(1'b0, '0, '0);
    #1 rst = 1'b0;

    // 1. Reset and idle: entry offered while reset is held must not be captured.
    drive2(1'b1, {5'd5, 5'd5}, 2'b11, {32'h1234, 32'h1234}, 1'b1, 32'h1, 32'h2);
    drive1(1'b1, 5'd5, 32'h1234);
    repeat (3) begin
      neg();
      check("rst_ready2", d2_mem_ready, 0);
      check("rst_ready1", d1_mem_ready, 0);
      check("rst_valid2", d2_wb_valid, 0);
      check("rst_occ2", d2_occupancy, 0);
      check("rst_wdata2", d2_wb_wdata, 0);
      check("rst_wd1", d1_wb_wd, 0);
      check("rst_occ1", d1_occupancy, 0);
    end
    tick();
    rst = 1'b1;
    idle2();
    drive1(1'b0, '0, '0);
    neg();
    check("post_rst_ready2", d2_mem_ready, 1);
    check("post_rst_ready1", d1_mem_ready, 1);
    check("post_rst_valid2", d2_wb_valid, 0);
    check("post_rst_valid1", d1_wb_valid, 0);
    check("post_rst_occ2", d2_occupancy, 0);
    tick();

    // 2. Streaming with wb_ready=1: one entry per cycle, occupancy stays 1.
    d2_wb_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      drive2(1'b1, {5'(k + 8), 5'(k)}, 2'b11, {32'hA100 + k, 32'hA000 + k},
             k[0], 32'h4000 + k, 32'h5000 + k);
      neg();
      check("t2_ready", d2_mem_ready, 1);
      if (k > 0) begin
        check("t2_occ", d2_occupancy, 1);
        check("t2_valid", d2_wb_valid, 1);
        check("t2_wdata", d2_wb_wdata[31:0], 32'hA000 + k - 1);
      end
      if (k == 1) check("t2_sq_wreg", d2_wb_wreg, 2'b10);
      tick();
    end
    idle2();
    neg();
    check("t2_last_occ", d2_occupancy, 1);
    check("t2_last_wdata", d2_wb_wdata, {32'hA107, 32'hA007});
    check("t2_last_wd", d2_wb_wd, {5'd15, 5'd7});
    tick();
    neg();
    check("t2_empty_occ", d2_occupancy, 0);
    check("t2_empty_valid", d2_wb_valid, 0);
    check("t2_empty_wdata", d2_wb_wdata, 0);
    tick();

    // 3. Back-pressure: third entry held off until the skid drains.
    d2_wb_ready = 1'b0;
    drive_tag(32'h11);
    neg();
    check("t3_ready0", d2_mem_ready, 1);
    check("t3_occ0", d2_occupancy, 0);
    tick();
    drive_tag(32'h22);
    neg();
    check("t3_occ1", d2_occupancy, 1);
    check("t3_ready1", d2_mem_ready, 1);
    check("t3_head11", d2_wb_wdata[31:0], 32'h11);
    tick();
    drive_tag(32'h33);
    neg();
    check("t3_occ2", d2_occupancy, 2);
    check("t3_ready2", d2_mem_ready, 0);
    check("t3_head11b", d2_wb_wdata[31:0], 32'h11);
    tick();
    neg();
    check("t3_hold_occ", d2_occupancy, 2);
    check("t3_hold_ready", d2_mem_ready, 0);
    tick();
    d2_wb_ready = 1'b1;
    neg();
    check("t3_ready_regd", d2_mem_ready, 0);
    check("t3_occ2b", d2_occupancy, 2);
    tick();
    neg();
    check("t3_head22", d2_wb_wdata[31:0], 32'h22);
    check("t3_ready_back", d2_mem_ready, 1);
    check("t3_occ1b", d2_occupancy, 1);
    tick();
    idle2();
    neg();
    check("t3_head33", d2_wb_wdata[31:0], 32'h33);
    check("t3_occ1c", d2_occupancy, 1);
    tick();
    neg();
    check("t3_drained", d2_occupancy, 0);
    tick();

    // 4. Flush at occupancy 2 with accept offered and drain requested.
    d2_wb_ready = 1'b0;
    drive_tag(32'h44);
    tick();
    drive_tag(32'h55);
    tick();
    drive_tag(32'h66);
    d2_flush = 1'b1;
    d2_wb_ready = 1'b1;
    neg();
    check("t4_pre_occ", d2_occupancy, 2);
    tick();
    d2_flush = 1'b0;
    idle2();
    neg();
    check("t4_occ", d2_occupancy, 0);
    check("t4_valid", d2_wb_valid, 0);
    check("t4_wd", d2_wb_wd, 0);
    check("t4_wreg", d2_wb_wreg, 0);
    check("t4_wdata", d2_wb_wdata, 0);
    check("t4_hilo", {d2_wb_whilo, d2_wb_hi, d2_wb_lo}, 0);
    check("t4_ready", d2_mem_ready, 1);
    tick();
    // Flush at occupancy 1 while mem_ready is 1: offered entry still dropped.
    drive_tag(32'h77);
    tick();
    drive_tag(32'h88);
    d2_flush = 1'b1;
    neg();
    check("t4b_ready", d2_mem_ready, 1);
    check("t4b_occ", d2_occupancy, 1);
    tick();
    d2_flush = 1'b0;
    idle2();
    neg();
    check("t4b_occ0", d2_occupancy, 0);
    check("t4b_valid", d2_wb_valid, 0);
    check("t4b_wdata", d2_wb_wdata, 0);
    tick();
    neg();
    check("t4b_still0", d2_occupancy, 0);
    tick();

    // 5. Zero-register squash.
    drive2(1'b1, {5'd0, 5'd0}, 2'b11, {32'hDEAD, 32'hDEAD}, 1'b1, 32'h1111_2222, 32'h3333_4444);
    tick();
    idle2();
    neg();
    check("t5_wd", d2_wb_wd, 0);
    check("t5_wreg", d2_wb_wreg, 2'b00);
    check("t5_wdata", d2_wb_wdata, {32'hDEAD, 32'hDEAD});
    check("t5_hilo", {d2_wb_whilo, d2_wb_hi, d2_wb_lo}, {1'b1, 32'h1111_2222, 32'h3333_4444});
    tick();
    drive2(1'b1, {5'd3, 5'd3}, 2'b11, {32'hDEAD, 32'hDEAD}, 1'b0, '0, '0);
    tick();
    idle2();
    neg();
    check("t5_wd3", d2_wb_wd, {5'd3, 5'd3});
    check("t5_wreg3", d2_wb_wreg, 2'b11);
    tick();
    drive2(1'b1, {5'd3, 5'd0}, 2'b11, {32'hBEEF, 32'hDEAD}, 1'b0, '0, '0);
    tick();
    idle2();
    neg();
    check("t5_mixed_wreg", d2_wb_wreg, 2'b10);
    tick();
    neg();
    check("t5_sb2_empty", 160'(exp2_q.size()), 0);
    tick();

    // 6. DEPTH=1: wb_ready toggles every cycle while mem_valid stays 1.
    acc_count = 0;
    for (int c = 0; c < 10; c++) begin
      d1_wb_ready = c[0];
      drive1(1'b1, 5'(acc_count % 3), 32'h100 + acc_count);
      neg();
      check("t6_ready", d1_mem_ready, (c == 0) ? 1'b1 : c[0]);
      if (c > 0) check("t6_occ", d1_occupancy, 1);
      acc = d1_mem_valid & d1_mem_ready;
      tick();
      if (acc) acc_count++;
    end
    drive1(1'b0, '0, '0);
    d1_wb_ready = 1'b1;
    neg();
    tick();
    neg();
    check("t6_occ_end", d1_occupancy, 0);
    check("t6_accepts", 160'(acc_count), 6);
    check("t6_drained", 160'(drained1), 6);
    check("t6_sb1_empty", 160'(exp1_q.size()), 0);
    tick();

    // 7. Asynchronous reset with two entries held.
    d2_wb_ready = 1'b0;
    drive_tag(32'h99);
    tick();
    drive_tag(32'hAA);
    tick();
    idle2();
    neg();
    check("t7_occ2", d2_occupancy, 2);
    #2 rst = 1'b0;
    #1;
    check("t7_occ", d2_occupancy, 0);
    check("t7_valid", d2_wb_valid, 0);
    check("t7_wdata", d2_wb_wdata, 0);
    check("t7_wd", d2_wb_wd, 0);
    check("t7_ready", d2_mem_ready, 0);
    exp2_q.delete();
    tick();
    rst = 1'b1;
    neg();
    check("t7_post_occ", d2_occupancy, 0);
    check("t7_post_ready", d2_mem_ready, 1);
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
